// File: rtl/sync_up_counter.sv
// -----------------------------------------------------------------------------
// sync_up_counter
//
// Synchronous up counter with a programmable bound. In free-run mode it counts
// 0..limit and wraps back to 0. In one-shot mode it stops at the bound and
// raises done. It also supports a parallel load, and it offers a combinational
// terminal-count output so that stages can be cascaded.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   en        in   count enable (only has an effect in RUN)
//   start     in   single-cycle request: clear the count and enter RUN
//   load      in   parallel load strobe (state is unchanged)
//   load_val  in   [WIDTH] value to load
//   limit     in   [WIDTH] terminal value, compared every cycle
//   one_shot  in   0 = wrap at limit, 1 = stop at limit (enter DONE)
//   counter   out  [WIDTH] registered count
//   tc        out  combinational terminal count (RUN && en && counter >= limit)
//   wrap      out  registered one-cycle pulse, coincident with counter == 0
//                  after a free-run wrap
//   done      out  registered, high while in DONE
//   busy      out  registered, high while in RUN
// -----------------------------------------------------------------------------
module sync_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             one_shot,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // The >= test catches a loaded value above limit, and it catches the
  // all-ones count. Because of this, the increment below never overflows.
  assign tc = (state_q == ST_RUN) && en && (counter_q >= limit);

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    wrap_d    = 1'b0;

    if (load) begin
      // Load wins over start and counting. The state is left alone.
      counter_d = load_val;
    end else if (start) begin
      // Start works from any state. A restart from RUN does not pulse wrap.
      counter_d = '0;
      state_d   = ST_RUN;
    end else if (tc) begin
      if (one_shot) begin
        state_d = ST_DONE;
      end else begin
        counter_d = '0;
        wrap_d    = 1'b1;
      end
    end else if ((state_q == ST_RUN) && en) begin
      counter_d = counter_q + 1'b1;
    end

    // busy and done are decoded from the next state. They therefore change
    // on the same edge as the state itself.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign counter = counter_q;
  assign wrap    = wrap_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: doc/sync_up_counter.md
# sync_up_counter

Synchronous, programmable-modulus up counter. It is the counting-up counterpart of the team's synchronous down counter and shares its clock/reset and `counter` output convention. It supports a free-running mode that wraps at a runtime limit, and a one-shot mode that stops at the limit and flags completion. It also provides parallel load and a terminal-count output for cascading. It sits in timer and sequencing paths wherever an up-count to a programmable bound is needed.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `en`  in  1  count enable. Counting pauses while low.
- `start`  in  1  single-cycle request. Clears the counter and begins counting (state RUN).
- `load`  in  1  parallel load strobe.
- `load_val`  in  WIDTH  value to load.
- `limit`  in  WIDTH  terminal value. The count runs 0..limit. Sampled every cycle.
- `one_shot`  in  1  mode select. 0 = free-run with wrap, 1 = stop at limit. Sampled at the terminal event.
- `counter`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count, combinational: `(state==RUN) && en && (counter >= limit)`.
- `wrap`  out  1  registered one-cycle pulse. High the cycle after a free-run wrap to 0.
- `done`  out  1  registered level. High while in DONE.
- `busy`  out  1  registered. High while in RUN.

## Operation
- **States:** IDLE, RUN, DONE. State is encoded internally; `busy` and `done` are decoded and registered.
- **Reset** (when `rst`=1 at an edge): state IDLE, `counter`=0, `wrap`=0, `done`=0, `busy`=0. Reset beats every other input, including mid-count.
- **Priority per cycle:** `rst` > `load` > `start` > counting.
- **load:**
  - `counter` <= `load_val` in any state.
  - State does not change.
  - No `wrap` pulse.
  - `start` in the same cycle is ignored.
- **IDLE:**
  - `counter` holds.
  - `start` -> RUN with `counter` <= 0.
  - `en` alone has no effect.
- **RUN, `en`=0:** `counter` holds.
- **RUN, `en`=1, `counter` < `limit`:** `counter` <= `counter`+1.
- **RUN, `en`=1, `counter` >= `limit`** (terminal event, `tc`=1):
  - `one_shot`=0: `counter` <= 0, `wrap` <= 1, stay in RUN.
  - `one_shot`=1: `counter` holds, go to DONE, `done` <= 1.
- **DONE:**
  - `counter` holds and `done` stays high.
  - `start` -> RUN with `counter` <= 0 and `done` <= 0.
  - `en` has no effect.
- **start while in RUN:** restarts the count, `counter` <= 0. No `wrap` pulse.
- **Loaded value above `limit`:** the next enabled increment in RUN is a terminal event (rule is `>=`). It wraps to 0 or enters DONE depending on `one_shot`.
- **limit = 0:**
  - Free-run: `counter` stays 0 and `wrap` pulses on every enabled cycle.
  - One-shot: DONE on the first enabled cycle after `start`.
- **limit changed mid-count:** takes effect immediately in the comparison.
- **Arithmetic:** unsigned, WIDTH bits. `limit` = all-ones gives the natural modulus 2^WIDTH. The increment never overflows because the `>=` test catches all-ones first.

## Timing
- `counter` updates one clock after the qualifying inputs are sampled.
- `wrap` is high for exactly one cycle, the same cycle `counter` first reads 0 after the wrap.
- `done`/`busy` change on the same edge as the state transition.
- `tc` is combinational and has zero latency. It is valid in the cycle before the wrap/DONE edge, for cascading into the next stage's `en`.
- Free-run period is `limit`+1 enabled cycles per wrap.
- From `start` to DONE in one-shot mode with `en` held high: `limit`+1 cycles.

## Test plan
- **Reset mid-count:** WIDTH=4, limit=9, start, `en`=1 for 5 cycles, then `rst`=1 for 1 cycle -> `counter`=0, IDLE, `busy`=0, `done`=0, `wrap`=0 on the next edge.
- **Free-run wrap:** limit=9, `one_shot`=0, start, `en`=1 continuously -> `counter` runs 0..9,0; `tc` high while `counter`=9; `wrap` high exactly when `counter` returns to 0, every 10 cycles.
- **One-shot:** limit=5, `one_shot`=1, start, `en`=1 -> `counter` stops at 5; `done`=1 and `busy`=0 from 6 cycles after start; further `en` holds 5; a new start gives `counter`=0, `done`=0, `busy`=1.
- **Enable gaps:** limit=15, `en` toggled 1,0,1,0 -> `counter` advances only on `en`=1 cycles; wrap after 16 enabled cycles, 15 -> 0.
- **Load priority:**
  - `load`=1, `load_val`=12, `start`=1 together in IDLE -> `counter`=12, state stays IDLE.
  - Then in RUN with limit=9 and `en`=1 -> `counter`=0 with a `wrap` pulse on the next edge (loaded value is above limit).
- **limit=0:** free-run with `en`=1 -> `counter`=0 and `wrap`=1 every cycle; one-shot -> `done`=1 one cycle after start.
